program_sequencer: RTL and testbench
====================================

# program_sequencer

Parametrised program counter with branch, jump and a hardware call/return stack; successor to the fixed 8-bit incrementing PC. Sits at the front of the fetch path: its `pc` output addresses instruction memory, and decode drives its control inputs. A two-state fault monitor freezes sequencing on stack misuse until reset.

## Interface
- `WIDTH`, 8: PC and address width.
- `OFF_WIDTH`, 8: signed branch offset width (must be <= WIDTH).
- `STACK_DEPTH`, 4: return-stack entries (>= 1).
- `RESET_ADDR`, 0: PC value after reset.
- `clk`  in  1: clock, all state updates on rising edge.
- `reset`  in  1: synchronous, active-low reset (asserted when 0).
- `enable_increment`  in  1: advance PC by 1.
- `stall`  in  1: hold all state this cycle.
- `load_en`  in  1: absolute jump to `load_addr`.
- `load_addr`  in  WIDTH: jump/call target.
- `branch_en`  in  1: relative branch.
- `branch_offset`  in  OFF_WIDTH: two's-complement offset.
- `call_en`  in  1: push return address, jump to `load_addr`.
- `ret_en`  in  1: pop return address into PC.
- `pc`  out  WIDTH: current PC, registered.
- `sp`  out  clog2(STACK_DEPTH+1): entries in use (0..STACK_DEPTH).
- `fault`  out  1: high in FAULT state.
- `fault_code`  out  2: 00 none, 01 overflow, 10 underflow, 11 call+ret conflict.

## Operation
- States: RUN, FAULT. Reset enters RUN.
- RUN, per cycle, first match wins:
  - `stall`: hold PC, SP, stack.
  - `call_en` & `ret_en`: go FAULT, code 11, PC holds.
  - `ret_en`: if SP=0 → FAULT, code 10, PC holds; else PC ← stack[SP-1], SP−1.
  - `call_en`: if SP=STACK_DEPTH → FAULT, code 01, PC holds, no push; else stack[SP] ← PC+1, SP+1, PC ← `load_addr`.
  - `load_en`: PC ← `load_addr`.
  - `branch_en`: PC ← PC + sign-extended `branch_offset` (relative to current PC, not PC+1).
  - `enable_increment`: PC ← PC+1.
  - none: hold.
- FAULT: all inputs ignored, PC/SP/stack frozen, `fault_code` held; exit only via reset.
- All PC arithmetic modulo 2^WIDTH: increment from all-ones wraps to 0; branch wraps both directions; pushed return address PC+1 wraps identically.
- Stack contents not reset; SP reset to 0 makes them unreachable.

## Timing
- Reset (`reset`=0 at rising edge): next cycle `pc`=RESET_ADDR, `sp`=0, `fault`=0, `fault_code`=00, state RUN. Overrides every other input, including in FAULT and mid-call.
- All outputs registered; one-cycle latency from control input at edge N to new `pc`/`sp`/`fault` after edge N.
- Back-to-back call/ret on consecutive cycles allowed; ret in the cycle after a call returns the just-pushed address.
- `fault` and `fault_code` rise together in the cycle after the offending edge.
- No handshake: inputs sampled every non-stalled RUN cycle; decode must hold them only one cycle.

## Configuration
- `PROGRAM_SEQUENCER_STACK_EN` defined: return stack, `call_en`/`ret_en` and fault codes 01/10/11 as above.
- Not defined: no stack storage; `call_en` behaves exactly as `load_en`; `ret_en` ignored; `sp` tied 0; FAULT unreachable, `fault`=0, `fault_code`=00 always.

## Test plan
- Reset then `enable_increment`=1 for 3 cycles → `pc` 0,1,2,3; `stall`=1 one cycle → `pc` stays 3; from `pc`=255 increment → 0.
- `pc`=10, `branch_offset`=8'hFC → `pc`=6; `pc`=250, offset +10 → 4; `load_en`, `load_addr`=0x80 with `enable_increment`=1 → 0x80.
- `pc`=5, call to 0x40 → `pc`=0x40, `sp`=1; ret next cycle → `pc`=6, `sp`=0.
- Four nested calls (DEPTH=4), fifth call → `fault`=1, `fault_code`=01, `pc` unchanged, `sp`=4; further increments ignored; `reset`=0 → `pc`=0, `sp`=0, `fault`=0.
- `ret_en` at `sp`=0 → code 10; `call_en`&`ret_en` together → code 11, `pc` unchanged.
- Macro undefined: call to 0x40 → `pc`=0x40, `sp`=0; `ret_en` → `pc` advances per lower-priority inputs only, `fault`=0.

Source files
------------

// File: rtl/program_sequencer.sv
// Purpose : program counter with increment, relative branch, absolute jump and an optional call/return stack.
// Latency : one cycle; a control input sampled at edge N sets pc/sp/fault after edge N.
// Backpres: stall freezes all state for the cycle; a stack fault freezes sequencing until reset.
//
// Ports
//   clk, reset (sync, active-low)      - clock and reset
//   enable_increment, stall            - advance by one / hold everything
//   load_en, load_addr                 - absolute jump (load_addr is also the call target)
//   branch_en, branch_offset           - pc-relative branch, offset sign-extended, relative to pc
//   call_en, ret_en                    - push pc+1 and jump / pop into pc
//   pc, sp, fault, fault_code          - registered outputs
//
// Build option: define PROGRAM_SEQUENCER_STACK_EN to include the return stack and
// fault monitor. Without it, call_en acts as load_en, ret_en is ignored, sp/fault are 0.
module program_sequencer #(
  parameter int               WIDTH       = 8,
  parameter int               OFF_WIDTH   = 8,
  parameter int               STACK_DEPTH = 4,
  parameter logic [WIDTH-1:0] RESET_ADDR  = '0
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             enable_increment,
  input  logic                             stall,
  input  logic                             load_en,
  input  logic [WIDTH-1:0]                 load_addr,
  input  logic                             branch_en,
  input  logic [OFF_WIDTH-1:0]             branch_offset,
  input  logic                             call_en,
  input  logic                             ret_en,
  output logic [WIDTH-1:0]                 pc,
  output logic [$clog2(STACK_DEPTH+1)-1:0] sp,
  output logic                             fault,
  output logic [1:0]                       fault_code
);

  localparam int               SP_W = $clog2(STACK_DEPTH+1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  // Size cast of a signed operand sign-extends, so this also works when OFF_WIDTH == WIDTH.
  logic [WIDTH-1:0] offset_ext;
  logic [WIDTH-1:0] pc_inc;

  assign offset_ext = WIDTH'($signed(branch_offset));
  assign pc_inc     = pc + ONE;

`ifdef PROGRAM_SEQUENCER_STACK_EN

  localparam int               IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [SP_W-1:0]  SP_FULL = SP_W'(STACK_DEPTH);
  localparam logic [SP_W-1:0]  SP_ONE  = SP_W'(1);

  typedef enum logic {RUN, FAULT} state_t;

  state_t           state;
  logic [WIDTH-1:0] stack [STACK_DEPTH];
  logic [IDX_W-1:0] push_idx;
  logic [IDX_W-1:0] pop_idx;
  logic             active;
  logic             do_push;

  // Index truncation is safe: push is blocked at sp == STACK_DEPTH and pop at sp == 0.
  assign push_idx = IDX_W'(sp);
  assign pop_idx  = IDX_W'(sp - SP_ONE);
  assign active   = (state == RUN) && !stall;
  assign do_push  = active && call_en && !ret_en && (sp != SP_FULL);

  // Stack storage carries no reset; sp returning to 0 makes stale entries unreachable.
  always_ff @(posedge clk) begin
    if (reset && do_push) begin
      stack[push_idx] <= pc_inc;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= RUN;
      pc         <= RESET_ADDR;
      sp         <= '0;
      fault      <= 1'b0;
      fault_code <= 2'b00;
    end else if (active) begin
      // Priority chain: first matching control wins; fault cases leave pc and sp untouched.
      if (call_en && ret_en) begin
        state      <= FAULT;
        fault      <= 1'b1;
        fault_code <= 2'b11;
      end else if (ret_en) begin
        if (sp == '0) begin
          state      <= FAULT;
          fault      <= 1'b1;
          fault_code <= 2'b10;
        end else begin
          pc <= stack[pop_idx];
          sp <= sp - SP_ONE;
        end
      end else if (call_en) begin
        if (sp == SP_FULL) begin
          state      <= FAULT;
          fault      <= 1'b1;
          fault_code <= 2'b01;
        end else begin
          pc <= load_addr;
          sp <= sp + SP_ONE;
        end
      end else if (load_en) begin
        pc <= load_addr;
      end else if (branch_en) begin
        pc <= pc + offset_ext;
      end else if (enable_increment) begin
        pc <= pc_inc;
      end
    end
    // FAULT (or stall): everything holds until reset.
  end

`else

  logic unused_ret;
  assign unused_ret = ret_en;

  assign sp         = '0;
  assign fault      = 1'b0;
  assign fault_code = 2'b00;

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc <= RESET_ADDR;
    end else if (!stall) begin
      if (call_en || load_en) begin
        pc <= load_addr;
      end else if (branch_en) begin
        pc <= pc + offset_ext;
      end else if (enable_increment) begin
        pc <= pc_inc;
      end
    end
  end

`endif

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer with default parameters (WIDTH=8, DEPTH=4).
// Inputs change 1 time unit after each rising edge; outputs are checked at that same point.
// Stack-specific steps run only when PROGRAM_SEQUENCER_STACK_EN is defined.
module tb_program_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable_increment;
  logic       stall;
  logic       load_en;
  logic [7:0] load_addr;
  logic       branch_en;
  logic [7:0] branch_offset;
  logic       call_en;
  logic       ret_en;
  logic [7:0] pc;
  logic [2:0] sp;
  logic       fault;
  logic [1:0] fault_code;

  int checks = 0;
  int errors = 0;

  program_sequencer dut (
    .clk              (clk),
    .reset            (reset),
    .enable_increment (enable_increment),
    .stall            (stall),
    .load_en          (load_en),
    .load_addr        (load_addr),
    .branch_en        (branch_en),
    .branch_offset    (branch_offset),
    .call_en          (call_en),
    .ret_en           (ret_en),
    .pc               (pc),
    .sp               (sp),
    .fault            (fault),
    .fault_code       (fault_code)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    enable_increment = 1'b0;
    stall            = 1'b0;
    load_en          = 1'b0;
    load_addr        = 8'h00;
    branch_en        = 1'b0;
    branch_offset    = 8'h00;
    call_en          = 1'b0;
    ret_en           = 1'b0;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic jump(input logic [7:0] addr);
    idle();
    load_en   = 1'b1;
    load_addr = addr;
    tick();
    idle();
  endtask

  initial begin
    idle();
    reset = 1'b0;
    tick();
    tick();
    check("reset_pc", pc, 8'h00);
    check("reset_sp", sp, 3'd0);
    check("reset_fault", fault, 1'b0);
    check("reset_code", fault_code, 2'b00);

    // Increment 0 -> 1 -> 2 -> 3, then a stall holds.
    reset = 1'b1;
    enable_increment = 1'b1;
    tick(); check("inc_1", pc, 8'h01);
    tick(); check("inc_2", pc, 8'h02);
    tick(); check("inc_3", pc, 8'h03);
    stall = 1'b1;
    tick(); check("stall_hold", pc, 8'h03);
    idle();
    tick(); check("no_ctrl_hold", pc, 8'h03);

    // Wrap on increment.
    jump(8'hFF);
    check("load_ff", pc, 8'hFF);
    enable_increment = 1'b1;
    tick(); check("inc_wrap", pc, 8'h00);

    // Negative branch, positive branch with wrap.
    jump(8'd10);
    branch_en = 1'b1; branch_offset = 8'hFC;
    tick(); check("branch_neg", pc, 8'd6);
    jump(8'd250);
    branch_en = 1'b1; branch_offset = 8'd10;
    tick(); check("branch_wrap", pc, 8'd4);
    jump(8'd2);
    branch_en = 1'b1; branch_offset = 8'hFC;
    tick(); check("branch_wrap_neg", pc, 8'hFE);

    // Load beats increment; branch beats increment.
    idle();
    load_en = 1'b1; load_addr = 8'h80; enable_increment = 1'b1;
    tick(); check("load_over_inc", pc, 8'h80);
    idle();
    branch_en = 1'b1; branch_offset = 8'h02; enable_increment = 1'b1;
    tick(); check("branch_over_inc", pc, 8'h82);
    idle();
    load_en = 1'b1; load_addr = 8'h33; branch_en = 1'b1; branch_offset = 8'h05;
    tick(); check("load_over_branch", pc, 8'h33);

    jump(8'd5);
    check("pc_before_call", pc, 8'd5);

`ifdef PROGRAM_SEQUENCER_STACK_EN
    call_en = 1'b1; load_addr = 8'h40;
    tick(); check("call_pc", pc, 8'h40); check("call_sp", sp, 3'd1);
    idle(); ret_en = 1'b1;
    tick(); check("ret_pc", pc, 8'd6); check("ret_sp", sp, 3'd0);

    // Pushed return address wraps like the PC.
    jump(8'hFF);
    call_en = 1'b1; load_addr = 8'h10;
    tick(); check("call_wrap_pc", pc, 8'h10);
    idle(); ret_en = 1'b1;
    tick(); check("ret_wrap_pc", pc, 8'h00);

    // Four nested calls fill the stack; the fifth overflows.
    jump(8'h10);
    for (int i = 0; i < 4; i++) begin
      idle(); call_en = 1'b1; load_addr = 8'h20 + 8'(i) * 8'h10;
      tick();
    end
    check("nest_pc", pc, 8'h50); check("nest_sp", sp, 3'd4);
    idle(); call_en = 1'b1; load_addr = 8'h60;
    tick();
    check("ovf_fault", fault, 1'b1); check("ovf_code", fault_code, 2'b01);
    check("ovf_pc", pc, 8'h50); check("ovf_sp", sp, 3'd4);
    idle(); enable_increment = 1'b1;
    tick(); check("fault_frozen_pc", pc, 8'h50); check("fault_code_held", fault_code, 2'b01);
    idle(); ret_en = 1'b1;
    tick(); check("fault_ignores_ret", sp, 3'd4);
    reset = 1'b0;
    tick();
    check("fault_reset_pc", pc, 8'h00); check("fault_reset_sp", sp, 3'd0);
    check("fault_reset_fault", fault, 1'b0); check("fault_reset_code", fault_code, 2'b00);
    reset = 1'b1;

    // Underflow.
    idle(); ret_en = 1'b1;
    tick();
    check("unf_fault", fault, 1'b1); check("unf_code", fault_code, 2'b10); check("unf_pc", pc, 8'h00);
    reset = 1'b0; idle(); tick(); reset = 1'b1;

    // Simultaneous call and return.
    jump(8'd7);
    call_en = 1'b1; ret_en = 1'b1; load_addr = 8'h40;
    tick();
    check("conf_fault", fault, 1'b1); check("conf_code", fault_code, 2'b11);
    check("conf_pc", pc, 8'd7); check("conf_sp", sp, 3'd0);
    reset = 1'b0; idle(); tick(); reset = 1'b1;

    // Stall blocks a call.
    jump(8'd9);
    stall = 1'b1; call_en = 1'b1; load_addr = 8'h44;
    tick(); check("stall_call_pc", pc, 8'd9); check("stall_call_sp", sp, 3'd0);
    idle();
`else
    call_en = 1'b1; load_addr = 8'h40;
    tick(); check("call_pc", pc, 8'h40); check("call_sp", sp, 3'd0);
    idle(); ret_en = 1'b1; enable_increment = 1'b1;
    tick(); check("ret_inc_pc", pc, 8'h41); check("ret_fault", fault, 1'b0);
    idle(); ret_en = 1'b1;
    tick(); check("ret_only_pc", pc, 8'h41);
    idle(); call_en = 1'b1; ret_en = 1'b1; load_addr = 8'h22;
    tick(); check("callret_pc", pc, 8'h22); check("callret_fault", fault, 1'b0);
    check("callret_code", fault_code, 2'b00); check("callret_sp", sp, 3'd0);
    idle(); stall = 1'b1; call_en = 1'b1; load_addr = 8'h44;
    tick(); check("stall_call_pc", pc, 8'h22);
    idle();
`endif

    // Reset overrides active controls.
    reset = 1'b0; enable_increment = 1'b1; load_en = 1'b1; load_addr = 8'h77;
    tick(); check("reset_override_pc", pc, 8'h00); check("reset_override_sp", sp, 3'd0);
    reset = 1'b1; idle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
